// File: rtl/p2s_rr_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit parallel-to-serial channel among N_REQ requesters.
// Optional macro P2S_RR_SCHED_GAP_EN inserts one idle GAP cycle after every serial slot.
module p2s_rr_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SRC_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   ser_load,
    output logic [WIDTH-1:0]       ser_word,
    output logic [SRC_W-1:0]       ser_src,
    output logic                   busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [SRC_W-1:0] SrcLast = SRC_W'(N_REQ - 1);

`ifdef P2S_RR_SCHED_GAP_EN
    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state;
    state_e           state_next;
    logic [CntW-1:0]  cnt;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] ptr_next;
    logic             any_valid;
    logic             accept_ok;
    logic             accept;

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = int'(ptr) + k;
            if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                grant     = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        accept_ok = 1'b0;
        case (state)
            StIdle:  accept_ok = 1'b1;
`ifdef P2S_RR_SCHED_GAP_EN
            StShift: accept_ok = 1'b0;
            StGap:   accept_ok = 1'b1;
`else
            StShift: accept_ok = (cnt == CntLast);
`endif
            default: accept_ok = 1'b0;
        endcase
    end

    assign accept   = accept_ok && any_valid && rst_n;
    assign ptr_next = (grant == SrcLast) ? '0 : grant + 1'b1;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = StShift;
        end else begin
            case (state)
                StIdle: state_next = StIdle;
                StShift: begin
                    if (cnt == CntLast) begin
`ifdef P2S_RR_SCHED_GAP_EN
                        state_next = StGap;
`else
                        state_next = StIdle;
`endif
                    end
                end
                default: state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            cnt      <= '0;
            ptr      <= '0;
            ser_load <= 1'b0;
            ser_word <= '0;
            ser_src  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != StIdle);
            ser_load <= accept;
            if (accept) begin
                cnt      <= '0;
                ptr      <= ptr_next;
                ser_word <= req_data[grant*WIDTH +: WIDTH];
                ser_src  <= grant;
            end else if (state == StShift && cnt != CntLast) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
